inst_encoder_loader: RTL and testbench

Streaming RV32I instruction encoder and instruction-memory loader. It accepts decoded instruction fields in the same format the instruction decoder produces, and re-encodes them into 32-bit machine words. It writes the words sequentially into instruction memory starting at a programmed base address. It is used to load programs and to run round-trip checks against inst_decoder.

---
 rtl/rv32i_pkg.sv | 29 ++
 rtl/inst_encoder.sv | 77 +++++++
 rtl/inst_encoder_loader.sv | 116 +++++++++++
 tb/tb_inst_encoder_loader.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I opcodes and loader types.
// Used by the encoder and the instruction-memory loader.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } ld_state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_OPCODE = 2'd1,
    ERR_RANGE  = 2'd2,
    ERR_ALIGN  = 2'd3
  } err_code_e;

endpackage

// File: rtl/inst_encoder.sv
// Combinational RV32I encoder: decoded fields -> machine word.
// Flags unknown opcodes, out-of-range and misaligned immediates.
module inst_encoder
  import rv32i_pkg::*;
(
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [20:0] immediate,
  output logic [31:0]        word,
  output logic               err,
  output err_code_e          err_code
);

  logic [20:0] imm;
  logic        fits12;
  logic        fits13;
  logic        shamt_ok;
  logic        is_shift;

  assign imm      = immediate;
  assign fits12   = (&imm[20:11]) | ~(|imm[20:11]);
  // 4095 passes the sign test but is above the even max 4094
  assign fits13   = ((&imm[20:12]) | ~(|imm[20:12]))
                 && (imm != 21'd4095);
  assign shamt_ok = ~(|imm[20:5]);
  assign is_shift = (opcode == OP_IMM)
                 && (funct3[1:0] == 2'b01);

  always_comb begin
    word     = '0;
    err_code = ERR_NONE;
    unique case (opcode)
      OP_R: begin
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        if (is_shift) begin
          word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          if (!shamt_ok) err_code = ERR_RANGE;
        end else begin
          word = {imm[11:0], rs1, funct3, rd, opcode};
          if (!fits12) err_code = ERR_RANGE;
        end
      end
      OP_STORE: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits12) err_code = ERR_RANGE;
      end
      OP_BRANCH: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3,
                imm[4:1], imm[11], opcode};
        if (!fits13)     err_code = ERR_RANGE;
        else if (imm[0]) err_code = ERR_ALIGN;
      end
      OP_LUI, OP_AUIPC: begin
        word = {imm[19:0], rd, opcode};
      end
      OP_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0]) err_code = ERR_ALIGN;
      end
      OP_SYSTEM: begin
        word = imm[0] ? 32'h0010_0073 : 32'h0000_0073;
      end
      default: begin
        err_code = ERR_OPCODE;
      end
    endcase
  end

  assign err = (err_code != ERR_NONE);

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams encoded RV32I words into instruction memory
// from a programmed base address, one output register deep.
module inst_encoder_loader
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic signed [20:0] immediate,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  words_written,
  output logic              busy,
  output logic              done
);

  ld_state_e   state_q, state_d;
  err_code_e   err_q;
  err_code_e   enc_code;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        accept;
  logic        wr_hs;
  logic        start_ok;
  logic        drain_end;

  inst_encoder u_enc (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .immediate (immediate),
    .word      (enc_word),
    .err       (enc_err),
    .err_code  (enc_code)
  );

  assign in_ready = (state_q == LOAD) && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_hs    = mem_we && mem_ready;
  assign start_ok = (state_q == IDLE) && start;
  assign busy     = (state_q != IDLE);
  assign err_code = err_q;

  always_comb begin
    state_d   = state_q;
    drain_end = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  if (accept && in_last) state_d = DRAIN;
      DRAIN: begin
        if (!mem_we || wr_hs) begin
          state_d   = IDLE;
          drain_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      err           <= 1'b0;
      err_q         <= ERR_NONE;
      words_written <= '0;
      done          <= 1'b0;
    end else begin
      done  <= drain_end;
      err   <= accept && enc_err;
      err_q <= (accept && enc_err) ? enc_code : ERR_NONE;
      if (start_ok) begin
        mem_addr      <= base_addr & ~ADDR_W'(3);
        words_written <= '0;
      end else if (wr_hs) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        if (~&words_written)
          words_written <= words_written + CNT_W'(1);
      end
      // a fresh word may overwrite the register in its handshake cycle
      if (accept && !enc_err) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc_word;
      end else if (wr_hs) begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: vector table,
// directed session sequences and randomized sessions vs a model.
module tb_inst_encoder_loader;
  import rv32i_pkg::*;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_last = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic signed [20:0] immediate = '0;
  logic mem_we;
  logic mem_ready = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic err;
  logic [1:0] err_code;
  logic [CNT_W-1:0] words_written;
  logic busy;
  logic done;

  inst_encoder_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err(err), .err_code(err_code),
    .words_written(words_written), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic signed [20:0] imm;
    logic [31:0] word;
    int          code;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [63:0] wq[$];
  int eq[$];
  int ecq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});
    if (err) begin
      eq.push_back(int'(err_code));
      ecq.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic [6:0] op, logic [2:0] f3,
                              logic [6:0] f7, logic [4:0] d, logic [4:0] s1,
                              logic [4:0] s2, int imm, logic [31:0] w,
                              int code);
    vec_t v;
    v.nm = nm; v.op = op; v.f3 = f3; v.f7 = f7;
    v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = imm[20:0]; v.word = w; v.code = code;
    return v;
  endfunction

  // Reference encoder from the RV32I field layouts, in plain arithmetic
  function automatic void model(input vec_t v, output logic [31:0] w,
                                output int code);
    int op, f3, f7, d, s1, s2, imm;
    op = int'(v.op); f3 = int'(v.f3); f7 = int'(v.f7);
    d = int'(v.rd); s1 = int'(v.rs1); s2 = int'(v.rs2);
    imm = int'(v.imm);
    w = '0; code = 0;
    case (op)
      'h33: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
              | (d << 7) | op;
      'h13, 'h03, 'h67: begin
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
          if (imm < 0 || imm > 31) code = 2;
          else w = (f7 << 25) | (imm << 20) | (s1 << 15) | (f3 << 12)
                 | (d << 7) | op;
        end else if (imm < -2048 || imm > 2047) code = 2;
        else w = ((imm & 'hFFF) << 20) | (s1 << 15) | (f3 << 12)
               | (d << 7) | op;
      end
      'h23: begin
        if (imm < -2048 || imm > 2047) code = 2;
        else w = (((imm >> 5) & 'h7F) << 25) | (s2 << 20) | (s1 << 15)
               | (f3 << 12) | ((imm & 'h1F) << 7) | op;
      end
      'h63: begin
        if (imm < -4096 || imm > 4094) code = 2;
        else if ((imm & 1) != 0) code = 3;
        else w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25)
               | (s2 << 20) | (s1 << 15) | (f3 << 12)
               | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
      end
      'h37, 'h17: w = ((imm & 'hFFFFF) << 12) | (d << 7) | op;
      'h6F: begin
        if ((imm & 1) != 0) code = 3;
        else w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12)
               | (d << 7) | op;
      end
      'h73: w = ((imm & 1) != 0) ? 32'h0010_0073 : 32'h0000_0073;
      default: code = 1;
    endcase
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    int k;
    k = $urandom_range(0, 11);
    case (k)
      0: v.op = 7'h33;  1: v.op = 7'h13;  2: v.op = 7'h03;
      3: v.op = 7'h67;  4: v.op = 7'h23;  5: v.op = 7'h63;
      6: v.op = 7'h37;  7: v.op = 7'h17;  8: v.op = 7'h6F;
      9: v.op = 7'h73;  10: v.op = 7'h7F; default: v.op = 7'h13;
    endcase
    v.f3 = 3'($urandom); v.f7 = 7'($urandom);
    v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
    k = $urandom_range(0, 17);
    case (k)
      0: v.imm = -21'sd4097; 1: v.imm = -21'sd4096; 2: v.imm = -21'sd2049;
      3: v.imm = -21'sd2048; 4: v.imm = -21'sd1;    5: v.imm = 21'sd0;
      6: v.imm = 21'sd1;     7: v.imm = 21'sd3;     8: v.imm = 21'sd31;
      9: v.imm = 21'sd32;    10: v.imm = 21'sd2047; 11: v.imm = 21'sd2048;
      12: v.imm = 21'sd4094; 13: v.imm = 21'sd4095; 14: v.imm = 21'sd4096;
      default: v.imm = 21'($urandom);
    endcase
    v.nm = "rnd"; v.word = '0; v.code = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    opcode = v.op; funct3 = v.f3; funct7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; immediate = v.imm;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input vec_t v, input logic last, input bit rnd);
    int t;
    t = 0;
    drive(v); in_last = last; in_valid = 1'b1;
    forever begin
      if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      lat++;
      if (lat > 100) begin
        chk("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    wq.delete(); eq.delete(); ecq.delete();
  endtask

  vec_t tbl[21];
  vec_t v_add, v_addi, v_sw, v_beq, v_jal, v_lui, v_ecall, v_ebrk;
  vec_t v_e2, v_e1, v_e3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, d0;
    logic [31:0] b, ew;
    int ec;
    logic [63:0] exp_w[$];
    int exp_e[$];

    v_add   = mk("add",    7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 0,       32'h002081B3, 0);
    v_addi  = mk("addi",   7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, -1,      32'hFFF00293, 0);
    v_sw    = mk("sw",     7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 8,       32'h0020A423, 0);
    v_beq   = mk("beq",    7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -4,      32'hFE208EE3, 0);
    v_jal   = mk("jal",    7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 8,       32'h008000EF, 0);
    v_lui   = mk("lui",    7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 'h12345, 32'h123452B7, 0);
    v_ecall = mk("ecall",  7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0,       32'h00000073, 0);
    v_ebrk  = mk("ebreak", 7'h73, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 1,       32'h00100073, 0);
    v_e2    = mk("addi2048", 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 2048,  32'h0, 2);
    v_e1    = mk("badop",  7'h7F, 3'd0, 7'h00, 5'd1, 5'd1, 5'd0, 0,       32'h0, 1);
    v_e3    = mk("beq3",   7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 3,       32'h0, 3);

    tbl[0]  = v_add;   tbl[1] = v_addi; tbl[2] = v_sw;   tbl[3] = v_beq;
    tbl[4]  = v_jal;   tbl[5] = v_lui;  tbl[6] = v_ecall; tbl[7] = v_ebrk;
    tbl[8]  = mk("slli",   7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 3,     32'h00311093, 0);
    tbl[9]  = mk("srai",   7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 3,     32'h40315093, 0);
    tbl[10] = mk("beqmin", 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -4096, 32'h80208063, 0);
    tbl[11] = mk("swmin",  7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, -2048, 32'h8020A023, 0);
    tbl[12] = v_e2; tbl[13] = v_e1; tbl[14] = v_e3;
    tbl[15] = mk("slli32", 7'h13, 3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32,    32'h0, 2);
    tbl[16] = mk("beq4096",7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 4096,  32'h0, 2);
    tbl[17] = mk("jalodd", 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 1,     32'h0, 3);
    tbl[18] = mk("lwmax",  7'h03, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 2047,  32'h7FF12083, 0);
    tbl[19] = mk("auipc",  7'h17, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 'hFFFFF, 32'hFFFFF097, 0);
    tbl[20] = mk("jalneg", 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, -2,    32'hFFFFF06F, 0);

    // reset values
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_words", 64'(words_written), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // one bundle per session from the vector table
    for (int i = 0; i < 21; i++) begin
      b = 32'h1000 + 32'(i * 16);
      clear_q();
      do_start(b);
      send(tbl[i], 1'b1, 1'b0);
      wait_done(lat);
      if (tbl[i].code == 0) begin
        chk({tbl[i].nm, "_nwr"}, 64'(wq.size()), 64'd1);
        if (wq.size() > 0) chk({tbl[i].nm, "_word"}, wq[0], {b, tbl[i].word});
      end else begin
        chk({tbl[i].nm, "_nwr"}, 64'(wq.size()), 64'd0);
        chk({tbl[i].nm, "_nerr"}, 64'(eq.size()), 64'd1);
        if (eq.size() > 0) chk({tbl[i].nm, "_code"}, 64'(eq[0]), 64'(tbl[i].code));
      end
    end

    // T1: single add, done one cycle after the write
    clear_q(); mem_ready = 1'b1;
    do_start(32'h100);
    chk("t1_busy", 64'(busy), 64'd1);
    send(v_add, 1'b1, 1'b0);
    wait_done(lat);
    chk("t1_done_lat", 64'(lat), 64'd1);
    chk("t1_nwr", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("t1_write", wq[0], {32'h100, 32'h002081B3});
    chk("t1_words", 64'(words_written), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // T2: three back-to-back words
    clear_q();
    do_start(32'h100);
    send(v_addi, 1'b0, 1'b0);
    send(v_sw, 1'b0, 1'b0);
    send(v_beq, 1'b1, 1'b0);
    wait_done(lat);
    chk("t2_nwr", 64'(wq.size()), 64'd3);
    if (wq.size() == 3) begin
      chk("t2_w0", wq[0], {32'h100, 32'hFFF00293});
      chk("t2_w1", wq[1], {32'h104, 32'h0020A423});
      chk("t2_w2", wq[2], {32'h108, 32'hFE208EE3});
    end
    chk("t2_words", 64'(words_written), 64'd3);

    // T3: memory stalls three cycles on the second word
    clear_q();
    do_start(32'h200);
    send(v_jal, 1'b0, 1'b0);
    send(v_lui, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_we", 64'(mem_we), 64'd1);
      chk("t3_stall_addr", 64'(mem_addr), 64'h204);
      chk("t3_stall_data", 64'(mem_wdata), 64'h123452B7);
      chk("t3_stall_rdy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    send(v_ecall, 1'b0, 1'b0);
    send(v_ebrk, 1'b1, 1'b0);
    wait_done(lat);
    chk("t3_nwr", 64'(wq.size()), 64'd4);
    if (wq.size() == 4) begin
      chk("t3_w0", wq[0], {32'h200, 32'h008000EF});
      chk("t3_w1", wq[1], {32'h204, 32'h123452B7});
      chk("t3_w2", wq[2], {32'h208, 32'h00000073});
      chk("t3_w3", wq[3], {32'h20C, 32'h00100073});
    end

    // T4: three rejected bundles in a row
    clear_q();
    do_start(32'h500);
    send(v_e2, 1'b0, 1'b0);
    send(v_e1, 1'b0, 1'b0);
    send(v_e3, 1'b1, 1'b0);
    wait_done(lat);
    chk("t4_nerr", 64'(eq.size()), 64'd3);
    if (eq.size() == 3) begin
      chk("t4_e0", 64'(eq[0]), 64'd2);
      chk("t4_e1", 64'(eq[1]), 64'd1);
      chk("t4_e2", 64'(eq[2]), 64'd3);
      chk("t4_back2back", 64'(ecq[2] - ecq[0]), 64'd2);
    end
    chk("t4_nwr", 64'(wq.size()), 64'd0);
    chk("t4_words", 64'(words_written), 64'd0);
    chk("t4_addr", 64'(mem_addr), 64'h500);

    // T5: reset while a write is pending
    clear_q();
    do_start(32'h300);
    mem_ready = 1'b0;
    send(v_addi, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_pending", 64'(mem_we), 64'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_we", 64'(mem_we), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rdy", 64'(in_ready), 64'd0);
    chk("t5_addr", 64'(mem_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_nodone", 64'(done_cnt), 64'(d0));
    chk("t5_nwr", 64'(wq.size()), 64'd0);
    do_start(32'h400);
    send(v_add, 1'b1, 1'b0);
    wait_done(lat);
    chk("t5_nwr2", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) chk("t5_write", wq[0], {32'h400, 32'h002081B3});

    // T6: address wraps; low base bits are ignored
    clear_q();
    do_start(32'hFFFF_FFFF);
    send(v_lui, 1'b0, 1'b0);
    send(v_add, 1'b1, 1'b0);
    wait_done(lat);
    chk("t6_nwr", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("t6_w0", wq[0], {32'hFFFF_FFFC, 32'h123452B7});
      chk("t6_w1", wq[1], {32'h0000_0000, 32'h002081B3});
    end

    // randomized sessions with random stalls and gaps
    for (int s = 0; s < 4; s++) begin
      int n, nw;
      vec_t v;
      clear_q(); exp_w.delete(); exp_e.delete();
      b = $urandom;
      do_start(b);
      n = 30; nw = 0;
      for (int k = 0; k < n; k++) begin
        v = rnd_vec();
        model(v, ew, ec);
        if (ec == 0) begin
          exp_w.push_back({(b & 32'hFFFF_FFFC) + 32'(4 * nw), ew});
          nw++;
        end else begin
          exp_e.push_back(ec);
        end
        repeat ($urandom_range(0, 2)) begin
          mem_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        send(v, (k == n - 1), 1'b1);
      end
      mem_ready = 1'b1;
      wait_done(lat);
      chk("rnd_nwr", 64'(wq.size()), 64'(exp_w.size()));
      for (int k = 0; k < exp_w.size() && k < wq.size(); k++)
        chk("rnd_write", wq[k], exp_w[k]);
      chk("rnd_nerr", 64'(eq.size()), 64'(exp_e.size()));
      for (int k = 0; k < exp_e.size() && k < eq.size(); k++)
        chk("rnd_err", 64'(eq[k]), 64'(exp_e[k]));
      chk("rnd_words", 64'(words_written), 64'(nw));
      chk("rnd_addr", 64'(mem_addr), 64'((b & 32'hFFFF_FFFC) + 32'(4 * nw)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
